// File: rtl/const_extend_pipe.sv
// Instruction-constant extender with a one-entry valid/ready output register.
// Define CONST_EXT_PREFIX_EN to build the PREFIX mode (101) and its two-state FSM.
module const_extend_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CONST_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         controle,
  input  logic [CONST_W-1:0] constante,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  constanteExtendida,
  output logic               ext_err
);

  logic              r_valid, r_err;
  logic [DATA_W-1:0] r_data;
  logic              w_valid_next, w_err_next;
  logic [DATA_W-1:0] w_data_next, w_norm;
  logic              w_accept, w_legal;

  assign in_ready           = !r_valid || out_ready;
  assign w_accept           = in_valid && in_ready;
  assign out_valid          = r_valid;
  assign constanteExtendida = r_data;
  assign ext_err            = r_err;

  always_comb begin
    w_norm  = '0;
    w_legal = 1'b1;
    case (controle)
      3'b000:  w_norm = {{(DATA_W-CONST_W+1){constante[CONST_W-2]}}, constante[CONST_W-2:0]};
      3'b001:  w_norm = {{(DATA_W-CONST_W){1'b0}}, constante};
      3'b010:  w_norm = {constante[7:0], {(DATA_W-8){1'b0}}};
      3'b011:  w_norm = {{(DATA_W-8){constante[7]}}, constante[7:0]};
      3'b100:  w_norm = {{(DATA_W-CONST_W){constante[CONST_W-1]}}, constante};
      default: w_legal = 1'b0;
    endcase
  end

`ifdef CONST_EXT_PREFIX_EN
  typedef enum logic {StIdle, StPrefixed} state_e;

  state_e             r_state, w_state_next;
  logic [CONST_W-1:0] r_prefix, w_prefix_next;
  logic [DATA_W-1:0]  w_joined;

  assign w_joined = DATA_W'({r_prefix, constante});
`endif

  always_comb begin
    w_valid_next = r_valid && !out_ready;
    w_data_next  = r_data;
    w_err_next   = r_err;
`ifdef CONST_EXT_PREFIX_EN
    w_state_next  = r_state;
    w_prefix_next = r_prefix;
`endif
    if (w_accept) begin
      w_valid_next = 1'b1;
      w_data_next  = w_norm;
      w_err_next   = 1'b0;
`ifdef CONST_EXT_PREFIX_EN
      if (controle == 3'b101) begin
        w_prefix_next = constante;
        w_state_next  = StPrefixed;
        if (r_state == StIdle) begin
          // A first prefix yields no result; the old one was consumed to allow acceptance.
          w_valid_next = 1'b0;
          w_data_next  = r_data;
          w_err_next   = r_err;
        end else begin
          w_data_next = '0;
          w_err_next  = 1'b1;
        end
      end else if (!w_legal) begin
        w_data_next  = '0;
        w_err_next   = 1'b1;
        w_state_next = StIdle;
      end else if (r_state == StPrefixed) begin
        w_data_next  = w_joined;
        w_state_next = StIdle;
      end
`else
      if (!w_legal) begin
        w_data_next = '0;
        w_err_next  = 1'b1;
      end
`endif
    end
    if (flush) begin
      w_valid_next = 1'b0;
      w_data_next  = '0;
      w_err_next   = 1'b0;
`ifdef CONST_EXT_PREFIX_EN
      w_state_next  = StIdle;
      w_prefix_next = '0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
    end
  end

`ifdef CONST_EXT_PREFIX_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_prefix <= '0;
    end else begin
      r_state  <= w_state_next;
      r_prefix <= w_prefix_next;
    end
  end
`endif

endmodule

// File: tb/tb_const_extend_pipe.sv
// Self-checking bench for const_extend_pipe (DATA_W=16, CONST_W=12): vector table,
// hand sequences for stalls/prefix/flush/reset, then random traffic against a model.
module tb_const_extend_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  controle = 3'd0;
  logic [11:0] constante = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] constanteExtendida;
  logic        ext_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid, m_err, m_pref;
  int m_data, m_prefix;

`ifdef CONST_EXT_PREFIX_EN
  localparam bit PrefixEn = 1'b1;
`else
  localparam bit PrefixEn = 1'b0;
`endif

  const_extend_pipe #(.DATA_W(16), .CONST_W(12)) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .controle           (controle),
    .constante          (constante),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .constanteExtendida (constanteExtendida),
    .ext_err            (ext_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit [2:0]  mode;
    bit [11:0] c;
    bit [15:0] exp_d;
    bit        exp_e;
  } vec_t;

  function automatic int ref_ext(input int mode, input int c);
    int v;
    case (mode)
      0: begin v = c % 2048; if (v >= 1024) v = v + 65536 - 2048; end
      1: v = c;
      2: v = (c % 256) * 256;
      3: begin v = c % 256; if (v >= 128) v = v + 65536 - 256; end
      4: begin v = c; if (v >= 2048) v = v + 65536 - 4096; end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_err = 0; m_pref = 0; m_data = 0; m_prefix = 0;
  endtask

  task automatic model_step();
    bit acc;
    int mode, c;
    mode = int'(controle);
    c    = int'(constante);
    acc  = in_valid && (!m_valid || out_ready);
    if (m_valid && out_ready) m_valid = 0;
    if (acc) begin
      if (PrefixEn && mode == 5) begin
        if (m_pref) begin m_valid = 1; m_data = 0; m_err = 1; end
        m_pref   = 1;
        m_prefix = c;
      end else if (mode >= 5) begin
        m_valid = 1; m_data = 0; m_err = 1; m_pref = 0;
      end else if (m_pref) begin
        m_valid = 1; m_data = (m_prefix * 4096 + c) % 65536; m_err = 0; m_pref = 0;
      end else begin
        m_valid = 1; m_data = ref_ext(mode, c); m_err = 0;
      end
    end
    if (flush) model_clear();
  endtask

  // Inputs are driven at a negedge; one call spans to the next negedge.
  task automatic cycle();
    #1;
    check1("in_ready", in_ready, !m_valid || out_ready);
    model_step();
    @(negedge clock);
    check1("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check16("data", constanteExtendida, 16'(m_data));
      check1("ext_err", ext_err, m_err);
    end
  endtask

  task automatic drive(input bit v, input bit [2:0] mode, input bit [11:0] c);
    in_valid = v; controle = mode; constante = c;
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_data", constanteExtendida, 16'h0000);
    check1("rst_ext_err", ext_err, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b000, 12'h400, 16'hFC00, 1'b0};
    vecs[1] = '{3'b000, 12'h3FF, 16'h03FF, 1'b0};
    vecs[2] = '{3'b001, 12'hFFF, 16'h0FFF, 1'b0};
    vecs[3] = '{3'b010, 12'h0AB, 16'hAB00, 1'b0};
    vecs[4] = '{3'b011, 12'h080, 16'hFF80, 1'b0};
    vecs[5] = '{3'b011, 12'h07F, 16'h007F, 1'b0};
    vecs[6] = '{3'b100, 12'h801, 16'hF801, 1'b0};
    vecs[7] = '{3'b100, 12'h7FF, 16'h07FF, 1'b0};
    vecs[8] = '{3'b111, 12'h123, 16'h0000, 1'b1};
    vecs[9] = '{3'b110, 12'hFFF, 16'h0000, 1'b1};

    model_clear();
    #1;
    check1("por_out_valid", out_valid, 1'b0);
    check16("por_data", constanteExtendida, 16'h0000);
    check1("por_ext_err", ext_err, 1'b0);
    check1("por_in_ready", in_ready, 1'b1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check1("post_rst_in_ready", in_ready, 1'b1);

    // Back-to-back table, in_valid held high, no idle cycles.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].mode, vecs[i].c);
      cycle();
      check1("tbl_valid", out_valid, 1'b1);
      check16("tbl_data", constanteExtendida, vecs[i].exp_d);
      check1("tbl_err", ext_err, vecs[i].exp_e);
    end
    drive(1'b0, 3'b000, 12'h000);
    cycle();

    // Stall: held result, blocked request, then same-cycle replacement.
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 12'h234);
    cycle();
    drive(1'b1, 3'b000, 12'h001);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check1("stall_in_ready", in_ready, 1'b0);
      check16("stall_data", constanteExtendida, 16'h0234);
    end
    out_ready = 1'b1;
    cycle();
    check16("stall_replace", constanteExtendida, 16'h0001);
    drive(1'b0, 3'b000, 12'h000);
    cycle();

    // Prefix combine (or illegal 101 without the feature).
    drive(1'b1, 3'b101, 12'h00F);
    cycle();
`ifdef CONST_EXT_PREFIX_EN
    check1("pfx_no_out", out_valid, 1'b0);
    drive(1'b1, 3'b001, 12'h234);
    cycle();
    check16("pfx_join", constanteExtendida, 16'hF234);
    check1("pfx_join_err", ext_err, 1'b0);
`else
    check16("p101_data", constanteExtendida, 16'h0000);
    check1("p101_err", ext_err, 1'b1);
`endif

    // Prefix then flush: next request uses its normal rule.
    drive(1'b1, 3'b101, 12'h0AA);
    cycle();
    drive(1'b0, 3'b000, 12'h000);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check1("flush_valid", out_valid, 1'b0);
    drive(1'b1, 3'b100, 12'h801);
    cycle();
    check16("post_flush", constanteExtendida, 16'hF801);
    check1("post_flush_err", ext_err, 1'b0);

    // Flush overrides a simultaneous acceptance.
    drive(1'b1, 3'b001, 12'h111);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check1("flush_override", out_valid, 1'b0);

    // Async reset while holding a result, then reset mid-prefix.
    drive(1'b1, 3'b001, 12'h555);
    cycle();
    drive(1'b0, 3'b000, 12'h000);
    async_reset_check();
    drive(1'b1, 3'b101, 12'h00F);
    cycle();
    drive(1'b0, 3'b000, 12'h000);
    async_reset_check();
    drive(1'b1, 3'b100, 12'h801);
    cycle();
    check16("post_rst_pfx", constanteExtendida, 16'hF801);
    drive(1'b0, 3'b000, 12'h000);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 12'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
